serial_operand_serializer_msb_first: RTL and testbench
======================================================

# serial_operand_serializer_msb_first

Upstream feeder for the MSB-first serial comparator. It accepts a pair of W-bit parallel operands over a valid/ready handshake and shifts them out one bit per cycle, most significant bit first. Before each word it issues a one-cycle comparator-restart pulse, so consecutive words are compared independently. It flags the last bit so a downstream sampler knows when the comparator result is final.

## Interface
- W, default 8: operand width; W >= 1.
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream offers an operand pair.
- up_ready  output  1  block accepts the pair this cycle.
- up_a  input  W  operand A, sampled on handshake.
- up_b  input  W  operand B, sampled on handshake.
- cmp_rst  output  1  restart strobe for the comparator's rst input.
- ser_valid  output  1  ser_a/ser_b carry a live bit.
- ser_first  output  1  current bit is the MSB (bit W-1).
- ser_last  output  1  current bit is the LSB (bit 0); comparator result is final this cycle.
- ser_a  output  1  serial A bit.
- ser_b  output  1  serial B bit.

## Operation
- FSM states, in a shared enum: ST_IDLE, ST_CLEAR, ST_SHIFT.
- Handshake: a transfer occurs on a posedge where up_valid & up_ready. Upstream holds up_a/up_b stable while up_valid & ~up_ready.
- up_ready = ~rst & (state == ST_IDLE | (state == ST_SHIFT & ser_last)).
- ST_IDLE:
  - With a handshake, load shift registers with up_a/up_b and go to ST_CLEAR.
  - Otherwise stay in ST_IDLE.
- ST_CLEAR:
  - Lasts one cycle.
  - Asserts cmp_rst = 1 and ser_valid = 0.
  - Loads the bit counter with W-1, then goes to ST_SHIFT.
- ST_SHIFT:
  - ser_valid = 1; ser_a/ser_b = MSB of each shift register.
  - Both shift registers shift left each cycle. The counter decrements.
  - ser_first when counter == W-1. ser_last when counter == 0.
  - On the ser_last cycle:
    - With a handshake: load the new pair and go to ST_CLEAR, with no idle gap.
    - Otherwise go to ST_IDLE.
- cmp_rst = rst | (state == ST_CLEAR).
- When ser_valid = 0, ser_a = ser_b = 0. This keeps the comparator in its equal state.
- W = 1: ST_SHIFT lasts exactly one cycle, with ser_first and ser_last both high.
- Counter width is max(1, $clog2(W)).

## Timing
- Reset values:
  - state = ST_IDLE; counter = 0; shift registers = 0.
  - During rst: up_ready = 0, cmp_rst = 1, ser_valid = ser_first = ser_last = ser_a = ser_b = 0.
- Handshake at edge ending cycle t:
  - Cycle t+1 is ST_CLEAR (cmp_rst = 1).
  - Cycles t+2 … t+W+1 carry bits W-1 … 0.
  - ser_last is high in cycle t+W+1.
- Maximum throughput: one operand pair per W+1 cycles.
- up_ready is combinational from state and rst only. It never depends on up_valid.
- Reset mid-word: the in-flight word is discarded. The cycle after rst deasserts is ST_IDLE with up_ready = 1.
- A handshake coinciding with rst is ignored, because up_ready = 0 during rst.

## Structure
- Package serial_serializer_pkg holds:
  - the state typedef (enum logic [1:0]: ST_IDLE, ST_CLEAR, ST_SHIFT);
  - the default width constant.
- One sub-module, serial_shift_reg_msb_first:
  - W-bit register with load, shift-left enable and serial MSB output;
  - instantiated once for A and once for B.
- The top level holds the FSM, the bit counter and the output decode.

## Test plan
- Single word, W=4, a=4'b1010, b=4'b1001, handshake at cycle 0:
  - cmp_rst in cycle 1;
  - cycles 2–5: ser_a = 1,0,1,0 and ser_b = 1,0,0,1;
  - ser_first in cycle 2, ser_last in cycle 5;
  - a downstream comparator shows a_greater_b in cycle 5.
- Back-to-back, W=4, up_valid held high with pairs (4'h3, 4'h3) then (4'h2, 4'h5):
  - second handshake lands in the first word's ser_last cycle;
  - cmp_rst follows immediately, with no idle cycle;
  - comparator ends with a_eq_b, then a_less_b.
- Backpressure, W=4, up_valid asserted during ST_SHIFT before ser_last:
  - up_ready = 0 until the ser_last cycle;
  - data is captured only at that cycle;
  - the held pair is transferred exactly once.
- Reset mid-word, W=8, rst pulsed in the 3rd shift cycle:
  - during rst: ser_valid = 0, cmp_rst = 1, up_ready = 0;
  - next cycle: ST_IDLE, up_ready = 1;
  - the remaining bits are never emitted.
- W=1, pairs (1, 0) then (0, 1) back-to-back:
  - each shift cycle has ser_first = ser_last = 1;
  - pattern is cmp_rst, bit, cmp_rst, bit with period 2.

Source files
------------

// File: rtl/serial_serializer_pkg.sv
// Shared types and constants for the MSB-first operand serializer.
// Holds the FSM state encoding and the default operand width.
package serial_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT
    } state_t;

    localparam int DEFAULT_W = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg_msb_first.sv
// W-bit parallel-load shift register, shifts left, exposes its MSB.
// Load has priority over shift so a new word can enter on the last bit.
module serial_shift_reg_msb_first
    import serial_serializer_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/serial_operand_serializer_msb_first.sv
// Accepts operand pairs and streams them MSB first to a serial comparator,
// preceded by a one-cycle comparator restart and tagged with first/last.
module serial_operand_serializer_msb_first
    import serial_serializer_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_a,
    input  logic [W-1:0] up_b,
    output logic         cmp_rst,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic         ser_a,
    output logic         ser_b
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          load;
    logic          shift;
    logic          msb_a;
    logic          msb_b;
    logic          live;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        up_ready  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_nxt   = CNT_TOP;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (cnt == '0) begin
                    // last bit: a waiting pair is taken with no idle gap
                    up_ready = 1'b1;
                    if (up_valid) begin
                        load      = 1'b1;
                        state_nxt = ST_CLEAR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (rst) begin
            up_ready = 1'b0;
            load     = 1'b0;
        end
    end

    serial_shift_reg_msb_first #(.W(W)) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (up_a),
        .msb   (msb_a)
    );

    serial_shift_reg_msb_first #(.W(W)) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (up_b),
        .msb   (msb_b)
    );

    assign live      = ~rst & (state == ST_SHIFT);
    assign cmp_rst   = rst | (state == ST_CLEAR);
    assign ser_valid = live;
    assign ser_first = live & (cnt == CNT_TOP);
    assign ser_last  = live & (cnt == '0);
    assign ser_a     = live & msb_a;
    assign ser_b     = live & msb_b;

endmodule

// File: tb/tb_serial_operand_serializer_msb_first.sv
// Bench for the MSB-first serializer at W=4, W=8 and W=1 side by side.
// Each DUT is tracked by a word timeline model: phase since handshake.
module tb_serial_operand_serializer_msb_first;

    logic       clk;
    logic       rst [3];
    logic       v [3];
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic       rdy [3];
    logic       crst [3];
    logic       sv [3];
    logic       sf [3];
    logic       sl [3];
    logic       sa [3];
    logic       sb [3];

    int         checks = 0;
    int         errors = 0;

    // model: ph = -1 idle, 0 restart cycle, k = k-th bit (MSB is k=1)
    int         ph [3];
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    bit         hs [3];
    bit         lasths [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_operand_serializer_msb_first #(.W(4)) dut4 (
        .clk(clk), .rst(rst[0]), .up_valid(v[0]), .up_ready(rdy[0]),
        .up_a(a[0][3:0]), .up_b(b[0][3:0]), .cmp_rst(crst[0]),
        .ser_valid(sv[0]), .ser_first(sf[0]), .ser_last(sl[0]),
        .ser_a(sa[0]), .ser_b(sb[0])
    );

    serial_operand_serializer_msb_first #(.W(8)) dut8 (
        .clk(clk), .rst(rst[1]), .up_valid(v[1]), .up_ready(rdy[1]),
        .up_a(a[1]), .up_b(b[1]), .cmp_rst(crst[1]),
        .ser_valid(sv[1]), .ser_first(sf[1]), .ser_last(sl[1]),
        .ser_a(sa[1]), .ser_b(sb[1])
    );

    serial_operand_serializer_msb_first #(.W(1)) dut1 (
        .clk(clk), .rst(rst[2]), .up_valid(v[2]), .up_ready(rdy[2]),
        .up_a(a[2][0:0]), .up_b(b[2][0:0]), .cmp_rst(crst[2]),
        .ser_valid(sv[2]), .ser_first(sf[2]), .ser_last(sl[2]),
        .ser_a(sa[2]), .ser_b(sb[2])
    );

    function automatic int wdth(int d);
        case (d)
            0: return 4;
            1: return 8;
            default: return 1;
        endcase
    endfunction

    // {ready, cmp_rst, valid, first, last, a, b}
    function automatic logic [6:0] expv(int d);
        logic [6:0] e;
        int w;
        int p;
        w = wdth(d);
        p = ph[d];
        e = '0;
        if (rst[d]) begin
            e[5] = 1'b1;
        end else if (p < 0) begin
            e[6] = 1'b1;
        end else if (p == 0) begin
            e[5] = 1'b1;
        end else begin
            e[6] = (p == w);
            e[4] = 1'b1;
            e[3] = (p == 1);
            e[2] = (p == w);
            e[1] = ea[d][w-p];
            e[0] = eb[d][w-p];
        end
        return e;
    endfunction

    task automatic chk(string tag, int d, logic [6:0] obs, logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s w%0d ph%0d observed %b expected %b",
                   tag, wdth(d), ph[d], obs, exp);
        end
    endtask

    task automatic cycle();
        logic [6:0] e;
        #2;
        for (int d = 0; d < 3; d++) begin
            e = expv(d);
            chk("out", d,
                {rdy[d], crst[d], sv[d], sf[d], sl[d], sa[d], sb[d]}, e);
            hs[d] = v[d] & e[6];
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                ph[d] = -1;
            end else if (hs[d]) begin
                ph[d] = 0;
                ea[d] = a[d];
                eb[d] = b[d];
            end else if (ph[d] == wdth(d)) begin
                ph[d] = -1;
            end else if (ph[d] >= 0) begin
                ph[d]++;
            end
            lasths[d] = hs[d];
        end
        #1;
    endtask

    task automatic send(int d, logic [7:0] pa, logic [7:0] pb);
        bit done;
        done = 1'b0;
        v[d] = 1'b1;
        a[d] = pa;
        b[d] = pb;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = lasths[d];
        end
        v[d] = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL send_timeout w%0d observed no handshake expected one",
                   wdth(d));
        end
    endtask

    task automatic drive_rand();
        for (int d = 0; d < 3; d++) begin
            rst[d] = ($urandom_range(0, 79) == 0);
            if (!(v[d] && !lasths[d])) begin
                v[d] = ($urandom_range(0, 2) != 0);
                a[d] = 8'($urandom);
                b[d] = 8'($urandom);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            v[d] = 1'b0;
            a[d] = '0;
            b[d] = '0;
            ph[d] = -1;
            ea[d] = '0;
            eb[d] = '0;
            hs[d] = 1'b0;
            lasths[d] = 1'b0;
        end
        repeat (2) cycle();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        cycle();

        // single word
        send(0, 8'b1010, 8'b1001);
        repeat (6) cycle();

        // back-to-back with valid held high
        send(0, 8'h3, 8'h3);
        send(0, 8'h2, 8'h5);
        repeat (6) cycle();

        // valid raised mid-word is held until the last bit
        send(0, 8'hC, 8'h4);
        repeat (2) cycle();
        send(0, 8'h7, 8'hE);
        repeat (6) cycle();

        // reset in the third shift cycle of a W=8 word
        send(1, 8'hA5, 8'h5A);
        repeat (3) cycle();
        rst[1] = 1'b1;
        cycle();
        rst[1] = 1'b0;
        repeat (10) cycle();

        // W=1 back-to-back
        send(2, 8'h1, 8'h0);
        send(2, 8'h0, 8'h1);
        repeat (3) cycle();

        repeat (800) begin
            drive_rand();
            cycle();
        end
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            v[d] = 1'b0;
        end
        repeat (12) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
